// File: rtl/my_pkg.sv
// Shared types for the I2C master slice: bus data types,
// master FSM states and quarter-bit phase encoding.
package my_pkg;

    typedef logic [7:0] byte_t;
    typedef logic [6:0] address_t;

    typedef logic [1:0] i2c_phase_t;

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_NACK,
        STOP
    } i2c_mstate_t;

    localparam i2c_phase_t PH_SAMPLE = 2'd2;
    localparam i2c_phase_t PH_LAST   = 2'd3;
    localparam logic [2:0] BIT_MSB   = 3'd7;

    // States that walk the bit counter through a byte.
    function automatic logic is_byte_state(input i2c_mstate_t s);
        return (s == ADDR) || (s == WRITE) || (s == READ);
    endfunction

    // Slots in which the target owns SDA and its level is captured.
    function automatic logic is_ack_state(input i2c_mstate_t s);
        return (s == ADDR_ACK) || (s == WRITE_ACK);
    endfunction

endpackage

// File: rtl/i2c_phase_gen.sv
// Quarter-bit timing for the I2C master: divides clk into four
// phases per SCL bit and flags the phase ends and the sample point.
module i2c_phase_gen
    import my_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    output i2c_phase_t ph,
    output logic       phase_tick,
    output logic       sample_en
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div;

    assign phase_tick = en && (div == DIV_LAST);
    assign sample_en  = phase_tick && (ph == PH_SAMPLE);

    // Counters park at zero while idle so every transaction
    // starts on a clean slot boundary.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div <= '0;
            ph  <= '0;
        end else if (!en) begin
            div <= '0;
            ph  <= '0;
        end else if (phase_tick) begin
            div <= '0;
            ph  <= ph + 2'd1;
        end else begin
            div <= div + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C initiator: START, address, one data byte
// (write or read), ACK handling and STOP on an open-drain bus.
module i2c_master
    import my_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     start_req,
    input  logic     rw,
    input  address_t addr,
    input  byte_t    wdata,
    output byte_t    rdata,
    output logic     busy,
    output logic     done,
    output logic     ack_err,
    output logic     scl_out,
    output logic     sda_out,
    input  logic     sda_in
);

    i2c_mstate_t state;
    i2c_mstate_t state_nxt;

    i2c_phase_t  ph;
    logic        phase_tick;
    logic        sample_en;
    logic        slot_end;
    logic        accept;
    logic        last_bit;
    logic        entering;

    logic [2:0]  bit_cnt;
    byte_t       cmd_q;
    byte_t       wdata_q;
    byte_t       shreg;

    assign busy     = (state != IDLE);
    assign accept   = start_req && !busy;
    assign slot_end = phase_tick && (ph == PH_LAST);
    assign last_bit = (bit_cnt == 3'd0);
    assign entering = (state_nxt != state);

    i2c_phase_gen #(
        .CLK_DIV    (CLK_DIV)
    ) u_phase (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (busy),
        .ph         (ph),
        .phase_tick (phase_tick),
        .sample_en  (sample_en)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // SCL is high in ph2/ph3 of every slot except the START
    // slot, where it stays released throughout.
    always_comb begin
        state_nxt = state;
        scl_out   = 1'b1;
        sda_out   = 1'b1;
        unique case (state)
            IDLE: begin
                if (accept) state_nxt = START;
            end
            START: begin
                sda_out = ~ph[1];
                if (slot_end) state_nxt = ADDR;
            end
            ADDR: begin
                scl_out = ph[1];
                sda_out = cmd_q[bit_cnt];
                if (slot_end && last_bit) state_nxt = ADDR_ACK;
            end
            ADDR_ACK: begin
                scl_out = ph[1];
                if (slot_end) begin
                    if (ack_err)       state_nxt = STOP;
                    else if (cmd_q[0]) state_nxt = READ;
                    else               state_nxt = WRITE;
                end
            end
            WRITE: begin
                scl_out = ph[1];
                sda_out = wdata_q[bit_cnt];
                if (slot_end && last_bit) state_nxt = WRITE_ACK;
            end
            WRITE_ACK: begin
                scl_out = ph[1];
                if (slot_end) state_nxt = STOP;
            end
            READ: begin
                scl_out = ph[1];
                if (slot_end && last_bit) state_nxt = READ_NACK;
            end
            READ_NACK: begin
                scl_out = ph[1];
                if (slot_end) state_nxt = STOP;
            end
            STOP: begin
                scl_out = ph[1];
                sda_out = (ph == PH_LAST);
                if (slot_end) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q   <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            cmd_q   <= {addr, rw};
            wdata_q <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt <= '0;
        end else if (slot_end) begin
            if (entering && is_byte_state(state_nxt)) begin
                bit_cnt <= BIT_MSB;
            end else if (is_byte_state(state)) begin
                bit_cnt <= bit_cnt - 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg <= '0;
        end else if (sample_en && (state == READ)) begin
            shreg <= {shreg[6:0], sda_in};
        end
    end

    // ack_err is sampled in ph2 so ADDR_ACK can branch on it
    // at the end of the same slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_err <= 1'b0;
        end else if (accept) begin
            ack_err <= 1'b0;
        end else if (sample_en && is_ack_state(state) && sda_in) begin
            ack_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done  <= 1'b0;
            rdata <= '0;
        end else begin
            done <= 1'b0;
            if ((state == STOP) && slot_end) begin
                done <= 1'b1;
                if (cmd_q[0]) rdata <= shreg;
            end
        end
    end

endmodule
